// File: rtl/trace_pkg.sv
// Shared types and constants for the PC trace buffer.
// Optional per-entry timestamps are enabled by the TRACE_TIMESTAMP_EN macro.
package trace_pkg;

  localparam int PC_W          = 4;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_TS_W  = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } trace_state_t;

  // Entry layout for the default configuration: timestamp above PC.
  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [DEFAULT_TS_W-1:0] ts;
`endif
    logic [PC_W-1:0]         pc;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with flush; a push is accepted when full only if a pop
// happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pc_trace_buffer.sv
// Captures changes of the CPU program counter into a FIFO for later readout.
// Define TRACE_TIMESTAMP_EN to tag each entry with a free-running timestamp.
module pc_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TS_W  = DEFAULT_TS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_W-1:0]        pc_trace,
  input  logic                   trace_en,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]        out_ts,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = PC_W + TS_W;
`else
  localparam int ENTRY_W = PC_W;
`endif

  trace_state_t       state;
  trace_state_t       next_state;
  logic               first_q;
  logic [PC_W-1:0]    last_pc;
  logic               push_req;
  logic               push_ok;
  logic               pop_fire;
  logic               drop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  assign out_valid = !empty;
  assign pop_fire  = out_valid && out_ready;
  assign push_ok   = push_req && !clear && (!full || pop_fire);
  assign drop      = push_req && !clear && full && !pop_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trace_en) next_state = CAPTURE;
      CAPTURE: begin
        if (drop)           next_state = FROZEN;
        else if (!trace_en) next_state = IDLE;
      end
      FROZEN:  next_state = FROZEN;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_comb begin
    push_req = 1'b0;
    if (state == CAPTURE) push_req = first_q || (pc_trace != last_pc);
  end

  // The first capture cycle after IDLE pushes even if the PC repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q  <= 1'b0;
      last_pc  <= '0;
      overflow <= 1'b0;
    end else begin
      first_q <= (state != CAPTURE) && (next_state == CAPTURE);
      if (push_ok) last_pc <= pc_trace;
      if (clear)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign wdata  = {ts_q, pc_trace};
  assign out_ts = rdata[ENTRY_W-1:PC_W];
`else
  assign wdata  = pc_trace;
`endif

  assign out_pc = rdata[PC_W-1:0];

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req && !clear),
    .pop   (out_ready),
    .flush (clear),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Scoreboard bench for pc_trace_buffer: expected entries are queued as pushes
// are driven and compared as the consumer pops them.
module tb_pc_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int TS_W  = 12;

  logic            clk;
  logic            rst;
  logic [PC_W-1:0] pc_trace;
  logic            trace_en;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      count;
  logic            overflow;

  int vectors     = 0;
  int miscompares = 0;

  trace_entry_t exp_q[$];

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] out_ts;
  logic [TS_W-1:0] tb_ts;

  always @(posedge clk) tb_ts <= rst ? '0 : tb_ts + 1'b1;
`endif

  pc_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_trace  (pc_trace),
    .trace_en  (trace_en),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
`ifdef TRACE_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [PC_W-1:0] pc);
    trace_entry_t e;
    e.pc = pc;
`ifdef TRACE_TIMESTAMP_EN
    e.ts = tb_ts;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    out_ready = 1'b0;
  endtask

  // Consumer side of the scoreboard: every accepted pop is checked.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pop_unexpected: got pc=%0d, expected no entry", out_pc);
      end else begin
        trace_entry_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc) begin
          miscompares++;
          $display("[TB] FAIL pop_pc: got %0d, expected %0d", out_pc, e.pc);
        end
`ifdef TRACE_TIMESTAMP_EN
        if (out_ts !== e.ts) begin
          miscompares++;
          $display("[TB] FAIL pop_ts: got %0d, expected %0d", out_ts, e.ts);
        end
`endif
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; trace_en = 1'b0; out_ready = 1'b0; pc_trace = '0;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    vectors++;
    if (out_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || out_pc !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset: got valid=%0b count=%0d ovf=%0b pc=%0d, expected 0 0 0 0",
               out_valid, count, overflow, out_pc);
    end
  endtask

  task automatic test_sequence();
    trace_en = 1'b1; pc_trace = 4'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      pc_trace = 4'(i);
      expect_push(4'(i));
      tick();
      if (i == 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
          miscompares++;
          $display("[TB] FAIL first_latency: got valid=%0b pc=%0d, expected 1 0", out_valid, out_pc);
        end
      end
    end
    trace_en = 1'b0;
    tick();
    vectors++;
    if (count !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL seq_count: got %0d, expected 4", count);
    end
    drain();
    vectors++;
    if (count !== 5'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL seq_drain: got count=%0d pending=%0d, expected 0 0", count, exp_q.size());
    end
  endtask

  task automatic test_dedup();
    trace_en = 1'b1; pc_trace = 4'd5;
    tick();
    expect_push(4'd5);
    repeat (10) tick();
    vectors++;
    if (count !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL dedup_hold: got count=%0d, expected 1", count);
    end
    trace_en = 1'b0;
    tick();
    trace_en = 1'b1;
    tick();
    expect_push(4'd5);
    tick();
    trace_en = 1'b0;
    tick();
    vectors++;
    if (count !== 5'd2) begin
      miscompares++;
      $display("[TB] FAIL dedup_reenable: got count=%0d, expected 2", count);
    end
    drain();
    vectors++;
    if (count !== 5'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL dedup_drain: got count=%0d pending=%0d, expected 0 0", count, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    trace_en = 1'b1; pc_trace = 4'd0;
    tick();
    for (int i = 0; i < 17; i++) begin
      pc_trace = 4'(i);
      if (i < 16) expect_push(4'(i));
      tick();
    end
    vectors++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_full: got count=%0d ovf=%0b, expected 16 1", count, overflow);
    end
    // While frozen a pop frees a slot, yet new PC values must not be pushed.
    pc_trace = 4'd9; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; pc_trace = 4'd10;
    tick();
    vectors++;
    if (count !== 5'd15 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_frozen: got count=%0d ovf=%0b, expected 15 1", count, overflow);
    end
    clear = 1'b1; trace_en = 1'b0;
    tick();
    clear = 1'b0;
    exp_q.delete();
    vectors++;
    if (count !== 5'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got count=%0d ovf=%0b valid=%0b, expected 0 0 0",
               count, overflow, out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    trace_en = 1'b1; pc_trace = 4'd0;
    tick();
    for (int i = 0; i < 16; i++) begin
      pc_trace = 4'(i);
      expect_push(4'(i));
      tick();
    end
    pc_trace = 4'd3; out_ready = 1'b1;
    expect_push(4'd3);
    tick();
    out_ready = 1'b0;
    vectors++;
    if (count !== 5'd16 || overflow !== 1'b0 || out_pc !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop: got count=%0d ovf=%0b head=%0d, expected 16 0 1",
               count, overflow, out_pc);
    end
    trace_en = 1'b0;
    tick();
    drain();
    vectors++;
    if (count !== 5'd0 || exp_q.size() != 0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got count=%0d pending=%0d ovf=%0b, expected 0 0 0",
               count, exp_q.size(), overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] last;
    logic [PC_W-1:0] p;
    trace_en = 1'b1; pc_trace = 4'd0;
    tick();
    p = 4'($urandom_range(0, 15));
    pc_trace = p;
    expect_push(p);
    tick();
    last = p;
    for (int i = 0; i < 30; i++) begin
      p = 4'($urandom_range(0, 15));
      pc_trace  = p;
      out_ready = ($urandom_range(0, 3) != 0);
      if (p != last) begin
        expect_push(p);
        last = p;
      end
      tick();
    end
    out_ready = 1'b0; trace_en = 1'b0;
    tick();
    drain();
    vectors++;
    if (count !== 5'd0 || exp_q.size() != 0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: got count=%0d pending=%0d ovf=%0b, expected 0 0 0",
               count, exp_q.size(), overflow);
    end
  endtask

  task automatic test_reset_midcapture();
    trace_en = 1'b1; pc_trace = 4'd0;
    tick();
    for (int i = 0; i < 6; i++) begin
      pc_trace = 4'(i + 2);
      expect_push(4'(i + 2));
      tick();
    end
    vectors++;
    if (count !== 5'd6) begin
      miscompares++;
      $display("[TB] FAIL mid_fill: got count=%0d, expected 6", count);
    end
    rst = 1'b1; clear = 1'b1;
    tick();
    rst = 1'b0; clear = 1'b0; trace_en = 1'b0;
    exp_q.delete();
    vectors++;
    if (out_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || out_pc !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got valid=%0b count=%0d ovf=%0b pc=%0d, expected 0 0 0 0",
               out_valid, count, overflow, out_pc);
    end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    trace_entry_t e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5000 && tb_ts != 12'd4094; i++) tick();
    trace_en = 1'b1; pc_trace = 4'd7;
    tick();
    e.pc = 4'd7; e.ts = 12'd4095;
    exp_q.push_back(e);
    tick();
    pc_trace = 4'd8;
    e.pc = 4'd8; e.ts = 12'd0;
    exp_q.push_back(e);
    tick();
    trace_en = 1'b0;
    tick();
    vectors++;
    if (count !== 5'd2 || out_ts !== 12'd4095) begin
      miscompares++;
      $display("[TB] FAIL ts_wrap: got count=%0d ts=%0d, expected 2 4095", count, out_ts);
    end
    drain();
    vectors++;
    if (count !== 5'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ts_drain: got count=%0d pending=%0d, expected 0 0", count, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_dedup();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_midcapture();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
